// File: rtl/picorv32_arb_pkg.sv
// picorv32_arb_pkg
// Shared types for the two-master picorv32 memory arbiter:
//   arb_state_e - arbiter FSM states (IDLE picks, REQ drives memory, ACK answers)
//   CNT_W       - width of the per-transaction wait counter
//   arb_req_t   - request fields latched from the winning master
package picorv32_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } arb_req_t;

endpackage

// File: rtl/picorv32_arb_rr.sv
// picorv32_arb_rr
// Combinational 2-way round-robin pick.
//   valid0_i, valid1_i - request valids of master 0 and master 1
//   last_grant_i       - index of the previously granted master
//   winner_o           - index of the master to serve next
//   any_o              - at least one master is requesting
module picorv32_arb_rr (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic winner_o,
    output logic any_o
);

    assign any_o = valid0_i | valid1_i;

    // On a tie the master that was not served last wins; otherwise the sole
    // requester wins (master 0 when neither requests, which is harmless).
    assign winner_o = (valid0_i & valid1_i) ? ~last_grant_i : valid1_i;

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter
// Shares one picorv32 native memory port between two masters. Round-robin
// per transaction, with an optional wait timeout that answers with a fixed
// error word so a hung memory cannot stall both requesters.
//   clk, resetn              - clock, asynchronous active-low reset
//   m0_* / m1_*              - upstream picorv32 memory ports (valid/instr/addr/
//                              wdata/wstrb in, ready/rdata out)
//   out_*                    - downstream memory port (valid/instr/addr/wdata/
//                              wstrb out, ready/rdata in)
//   timeout_err              - one-cycle pulse alongside a timed-out response
//   grant                    - index of the current or last granted master
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        out_valid,
    output logic        out_instr,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wstrb,
    input  logic        out_ready,
    input  logic [31:0] out_rdata,

    output logic        timeout_err,
    output logic        grant
);

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    arb_req_t         req_q, req_d;
    logic             valid_q, valid_d;
    logic             rdy0_q, rdy0_d;
    logic             rdy1_q, rdy1_d;
    logic             terr_q, terr_d;
    logic [31:0]      resp_q, resp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rr_win;
    logic             rr_any;
    arb_req_t         win_req;
    logic             expire;

    picorv32_arb_rr u_rr (
        .valid0_i     (m0_valid),
        .valid1_i     (m1_valid),
        .last_grant_i (grant_q),
        .winner_o     (rr_win),
        .any_o        (rr_any)
    );

    // Only the winner's fields are ever looked at.
    assign win_req = rr_win ? '{m1_instr, m1_addr, m1_wdata, m1_wstrb}
                            : '{m0_instr, m0_addr, m0_wdata, m0_wstrb};

    // Counter holds the number of REQ cycles already waited; the last allowed
    // wait cycle is the one where it reads TIMEOUT-1.
    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        req_d   = req_q;
        valid_d = valid_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        terr_d  = 1'b0;
        resp_d  = resp_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    state_d = ST_REQ;
                    grant_d = rr_win;
                    req_d   = win_req;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                // out_ready takes priority over an expiry on the same cycle.
                if (out_ready || expire) begin
                    state_d = ST_ACK;
                    valid_d = 1'b0;
                    resp_d  = out_ready ? out_rdata : ERR_RDATA;
                    terr_d  = ~out_ready;
                    rdy0_d  = ~grant_q;
                    rdy1_d  = grant_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // ACK never samples requests, so the served master has time to
            // drop its valid before IDLE looks again.
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b1;
            req_q   <= '0;
            valid_q <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            terr_q  <= 1'b0;
            resp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            terr_q  <= terr_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_instr   = req_q.instr;
    assign out_addr    = req_q.addr;
    assign out_wdata   = req_q.wdata;
    assign out_wstrb   = req_q.wstrb;
    assign m0_ready    = rdy0_q;
    assign m1_ready    = rdy1_q;
    assign m0_rdata    = resp_q;
    assign m1_rdata    = resp_q;
    assign timeout_err = terr_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
module tb_picorv32_mem_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        out_valid, out_instr, out_ready;
    logic [31:0] out_addr, out_wdata, out_rdata;
    logic [3:0]  out_wstrb;
    logic        timeout_err, grant;

    int errors = 0;
    int checks = 0;

    picorv32_mem_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_addr(out_addr),
        .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_ready(out_ready),
        .out_rdata(out_rdata), .timeout_err(timeout_err), .grant(grant)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: is a transaction open, how long it has
    // waited, and whether the answer cycle is being shown.
    bit          mdl_open;
    bit          mdl_answering;
    int          mdl_waited;
    bit          e_grant;
    bit          e_valid, e_instr, e_r0, e_r1, e_terr;
    logic [31:0] e_addr, e_wdata, e_resp;
    logic [3:0]  e_wstrb;

    function automatic void model_reset();
        mdl_open = 0; mdl_answering = 0; mdl_waited = 0;
        e_grant = 1; e_valid = 0; e_instr = 0; e_r0 = 0; e_r1 = 0; e_terr = 0;
        e_addr = 0; e_wdata = 0; e_wstrb = 0; e_resp = 0;
    endfunction

    function automatic void model_step();
        bit done;
        if (!resetn) begin
            model_reset();
        end else if (mdl_answering) begin
            mdl_answering = 0; e_r0 = 0; e_r1 = 0; e_terr = 0;
        end else if (mdl_open) begin
            done = 0;
            if (out_ready) begin
                e_resp = out_rdata; e_terr = 0; done = 1;
            end else if (mdl_waited == TO - 1) begin
                e_resp = ERR; e_terr = 1; done = 1;
            end else if (mdl_waited < 65535) begin
                mdl_waited++;
            end
            if (done) begin
                mdl_open = 0; mdl_answering = 1; e_valid = 0;
                e_r0 = (e_grant == 0); e_r1 = (e_grant == 1);
            end
        end else if (m0_valid || m1_valid) begin
            if (m0_valid && m1_valid) e_grant = !e_grant;
            else                      e_grant = m1_valid;
            if (e_grant) begin
                e_instr = m1_instr; e_addr = m1_addr; e_wdata = m1_wdata; e_wstrb = m1_wstrb;
            end else begin
                e_instr = m0_instr; e_addr = m0_addr; e_wdata = m0_wdata; e_wstrb = m0_wstrb;
            end
            mdl_open = 1; mdl_waited = 0; e_valid = 1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("out_valid",   32'(out_valid),   32'(e_valid));
        chk("out_instr",   32'(out_instr),   32'(e_instr));
        chk("out_addr",    out_addr,         e_addr);
        chk("out_wdata",   out_wdata,        e_wdata);
        chk("out_wstrb",   32'(out_wstrb),   32'(e_wstrb));
        chk("m0_ready",    32'(m0_ready),    32'(e_r0));
        chk("m1_ready",    32'(m1_ready),    32'(e_r1));
        chk("m0_rdata",    m0_rdata,         e_resp);
        chk("m1_rdata",    m1_rdata,         e_resp);
        chk("timeout_err", 32'(timeout_err), 32'(e_terr));
        chk("grant",       32'(grant),       32'(e_grant));
    endtask

    // One clock: step the reference, compare away from the edge, then let the
    // served master drop its request the way picorv32 does.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (e_r0) m0_valid = 0;
        if (e_r1) m1_valid = 0;
    endtask

    initial begin
        int n;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        out_ready = 0; out_rdata = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_grant",     32'(grant), 1);
        chk("rst_m0_ready",  32'(m0_ready), 0);
        chk("rst_m1_ready",  32'(m1_ready), 0);
        chk("rst_out_addr",  out_addr, 0);
        chk("rst_rdata",     m0_rdata, 0);
        resetn = 1;

        // Single read from m0
        m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 0;
        tick();
        chk("rd_out_valid", 32'(out_valid), 1);
        chk("rd_out_addr",  out_addr, 32'h100);
        chk("rd_grant",     32'(grant), 0);
        out_ready = 1; out_rdata = 32'h12345678;
        tick();
        chk("rd_m0_ready", 32'(m0_ready), 1);
        chk("rd_m0_rdata", m0_rdata, 32'h12345678);
        chk("rd_m1_ready", 32'(m1_ready), 0);
        out_ready = 0;
        tick();
        chk("rd_m0_ready_once", 32'(m0_ready), 0);
        tick();

        // Tie straight after reset
        resetn = 0;
        tick();
        resetn = 1;
        m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20;
        tick();
        chk("tie_first_grant", 32'(grant), 0);
        chk("tie_first_addr",  out_addr, 32'h10);
        out_ready = 1; out_rdata = 32'h11; tick(); out_ready = 0;
        chk("tie_first_ready", 32'(m0_ready), 1);
        tick();
        tick();
        chk("tie_second_grant", 32'(grant), 1);
        chk("tie_second_addr",  out_addr, 32'h20);
        out_ready = 1; out_rdata = 32'h22; tick(); out_ready = 0;
        chk("tie_second_ready", 32'(m1_ready), 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            m0_valid = 1; m1_valid = 1;
            tick();
            chk("tie_seq_grant", 32'(grant), 32'(k % 2));
            out_ready = 1; tick(); out_ready = 0;
            tick();
        end
        m0_valid = 0; m1_valid = 0;
        tick();

        // Write pass-through from m1
        m1_valid = 1; m1_instr = 0; m1_addr = 32'h40; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'b0011;
        tick();
        chk("wr_grant", 32'(grant), 1);
        chk("wr_wstrb", 32'(out_wstrb), 32'h3);
        chk("wr_wdata", out_wdata, 32'hA5A5A5A5);
        repeat (3) begin
            tick();
            chk("wr_hold_valid", 32'(out_valid), 1);
            chk("wr_hold_wstrb", 32'(out_wstrb), 32'h3);
        end
        out_ready = 1; tick(); out_ready = 0;
        chk("wr_m1_ready", 32'(m1_ready), 1);
        chk("wr_m0_ready", 32'(m0_ready), 0);
        tick();

        // Timeout with out_ready held low
        m0_valid = 1; m0_addr = 32'h200; m0_wstrb = 0;
        tick();
        n = 0;
        while (m0_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd8);
        chk("to_rdata",  m0_rdata, 32'hDEADBEEF);
        chk("to_err",    32'(timeout_err), 1);
        tick();
        chk("to_err_pulse", 32'(timeout_err), 0);

        // out_ready on the expiry cycle
        m0_valid = 1;
        tick();
        repeat (7) tick();
        chk("exp_not_yet", 32'(m0_ready), 0);
        out_ready = 1; out_rdata = 32'hCAFEF00D;
        tick();
        out_ready = 0;
        chk("exp_ready", 32'(m0_ready), 1);
        chk("exp_rdata", m0_rdata, 32'hCAFEF00D);
        chk("exp_no_err", 32'(timeout_err), 0);
        tick();

        // Reset during REQ
        m0_valid = 1; m0_addr = 32'h300;
        tick();
        chk("mid_valid", 32'(out_valid), 1);
        #2 resetn = 0;
        #1;
        chk("rst_async_drop", 32'(out_valid), 0);
        chk("rst_async_grant", 32'(grant), 1);
        model_reset();
        m0_valid = 0; out_ready = 1;
        tick();
        chk("rst_no_ready", 32'(m0_ready), 0);
        out_ready = 0; resetn = 1;
        m0_valid = 1; m0_addr = 32'h400; m1_valid = 1; m1_addr = 32'h500;
        tick();
        chk("post_rst_grant", 32'(grant), 0);
        chk("post_rst_addr",  out_addr, 32'h400);
        out_ready = 1; out_rdata = 32'h55; tick(); out_ready = 0;
        chk("post_rst_ready", 32'(m0_ready), 1);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!m0_valid && $urandom_range(0, 2) == 0) begin
                m0_valid = 1; m0_instr = 1'($urandom); m0_addr = $urandom;
                m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            end
            if (!m1_valid && $urandom_range(0, 2) == 0) begin
                m1_valid = 1; m1_instr = 1'($urandom); m1_addr = $urandom;
                m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 4) == 0);
            out_rdata = $urandom;
            tick();
        end
        m0_valid = 0; m1_valid = 0; out_ready = 0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
